// File: rtl/kernel_ctrl_pkg.sv
// Shared definitions for the kernel BRAM controller.
//   - default width constants for the kernel word, BRAM address and burst length
//   - controller state encoding
package kernel_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 36;
    localparam int ADDR_WIDTH_DEF = 11;
    localparam int LEN_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/kernel_rd_addr_gen.sv
// Burst read address / length counter.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : capture a new burst (base, len)
//   step        : advance to the next word of the burst
//   base, len   : burst start address and length-minus-one
//   addr        : address of the next read to issue (wraps modulo 2**ADDR_WIDTH)
//   last_issue  : the read being issued now is the final one of the burst
module kernel_rd_addr_gen
    import kernel_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_issue
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;

    // The first word (base) is issued by the controller straight from the
    // request, so the counter preloads base+1 and counts remaining issues.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load) begin
            addr_d = base + ADDR_WIDTH'(1);
            rem_d  = len;
        end else if (step) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            rem_d  = rem_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr       = addr_q;
    assign last_issue = (rem_q == '0);

endmodule

// File: rtl/kernel_bram_ctrl.sv
// Kernel BRAM controller: single-word kernel loads and read bursts on one
// BRAM port.
//   clk, rst_n                    : clock, synchronous active-low reset
//   cfg_valid/ready, addr, data   : kernel word write request
//   rd_valid/ready, base, len     : read burst request (len = words - 1)
//   out_valid, out_data, out_last : burst read data, no backpressure
//   bram_en/we/addr/wdata/rdata   : BRAM port A (read latency 1)
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | accepting requests; write has priority over burst
// WRITE    | one-cycle BRAM write of the accepted kernel word
// BURST    | one read issued per cycle until the last word
// DRAIN    | last read data returning; no new requests
module kernel_bram_ctrl
    import kernel_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    input  logic [DATA_WIDTH-1:0] bram_rdata
);

    ctrl_state_e           state_q, state_d;
    logic                  bram_en_q, bram_en_d;
    logic                  bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_wdata_q, bram_wdata_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;

    logic                  in_idle;
    logic                  gen_load;
    logic                  gen_step;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_last;

    assign in_idle  = (state_q == ST_IDLE);
    assign cfg_ready = in_idle;
    // A simultaneous write holds the burst off until the next IDLE cycle.
    assign rd_ready  = in_idle && !cfg_valid;
    assign gen_load  = in_idle && !cfg_valid && rd_valid;
    assign gen_step  = (state_q == ST_BURST) && !gen_last;

    kernel_rd_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (gen_load),
        .step       (gen_step),
        .base       (rd_base),
        .len        (rd_len),
        .addr       (gen_addr),
        .last_issue (gen_last)
    );

    // BRAM port signals are computed for the next state so that they are
    // registered and line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        bram_en_d    = 1'b0;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    state_d      = ST_WRITE;
                    bram_en_d    = 1'b1;
                    bram_we_d    = 1'b1;
                    bram_addr_d  = cfg_addr;
                    bram_wdata_d = cfg_data;
                end else if (rd_valid) begin
                    state_d     = ST_BURST;
                    bram_en_d   = 1'b1;
                    bram_addr_d = rd_base;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_BURST: begin
                if (gen_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    bram_en_d   = 1'b1;
                    bram_addr_d = gen_addr;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Every BURST cycle issues a read; its data is presented one cycle later.
    always_comb begin
        out_valid_d = (state_q == ST_BURST);
        out_last_d  = (state_q == ST_BURST) && gen_last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    // BRAM read data arrives in the out_valid cycle; gated so it reads zero
    // whenever no word is being presented.
    assign out_data   = out_valid_q ? bram_rdata : '0;

endmodule

// File: tb/tb_kernel_bram_ctrl.sv
// Testbench for kernel_bram_ctrl: behavioural BRAM, shadow memory and
// scoreboard queues for expected writes, read issues and output words.
module tb_kernel_bram_ctrl;

    localparam int DW = 36;
    localparam int AW = 11;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid, cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_base;
    logic [LW-1:0] rd_len;
    logic          out_valid, out_last;
    logic [DW-1:0] out_data;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata, bram_rdata;

    always #5 clk = ~clk;

    kernel_bram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_base    (rd_base),
        .rd_len     (rd_len),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    logic [DW-1:0] mem    [2**AW];
    logic [DW-1:0] shadow [2**AW];

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            bram_rdata <= mem[bram_addr];
        end
    end

    function automatic logic [DW-1:0] pat(int a);
        return (DW'(a) * 36'h10001) ^ 36'hA5A5A5A5A;
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [AW-1:0] addr; int cyc; } rd_exp_t;
    typedef struct { logic [DW-1:0] data; logic last; int cyc; } word_exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_exp_t;

    rd_exp_t   rd_q[$];
    word_exp_t word_q[$];
    wr_exp_t   wr_q[$];

    int cyc = 0;
    int prev_out_cyc = -1;
    int last_out_cyc = -1;
    always @(posedge clk) cyc <= cyc + 1;

    rd_exp_t   m_rd;
    word_exp_t m_wd;
    wr_exp_t   m_wr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_en && bram_we) begin
                if (wr_q.size() == 0) chk("unexp_write", bram_we, 0);
                else begin
                    m_wr = wr_q.pop_front();
                    chk("wr_addr", bram_addr, m_wr.addr);
                    chk("wr_data", bram_wdata, m_wr.data);
                    chk("wr_cyc", cyc, m_wr.cyc);
                end
            end else if (bram_en) begin
                if (rd_q.size() == 0) chk("unexp_read", bram_en, 0);
                else begin
                    m_rd = rd_q.pop_front();
                    chk("rd_addr", bram_addr, m_rd.addr);
                    chk("rd_cyc", cyc, m_rd.cyc);
                end
            end
            if (out_valid) begin
                prev_out_cyc = last_out_cyc;
                last_out_cyc = cyc;
                if (word_q.size() == 0) chk("unexp_out", out_valid, 0);
                else begin
                    m_wd = word_q.pop_front();
                    chk("out_data", out_data, m_wd.data);
                    chk("out_last", out_last, m_wd.last);
                    chk("out_cyc", cyc, m_wd.cyc);
                end
            end else begin
                chk("stray_last", out_last, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cfg_ready) begin
                wr_q.push_back('{a, d, cyc + 1});
                shadow[a] = d;
                tick();
                cfg_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("wr_timeout", cfg_ready, 1);
        cfg_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] base, input logic [LW-1:0] len, output int acc);
        rd_valid = 1'b1;
        rd_base  = base;
        rd_len   = len;
        acc      = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rd_ready) begin
                acc = cyc;
                for (int i = 0; i <= int'(len); i++) begin
                    logic [AW-1:0] ai;
                    ai = base + AW'(i);
                    rd_q.push_back('{ai, cyc + 1 + i});
                    word_q.push_back('{shadow[ai], (i == int'(len)), cyc + 2 + i});
                end
                tick();
                rd_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("rd_timeout", rd_ready, 1);
        rd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, first;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        rd_valid  = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        rd_base   = '0;
        rd_len    = '0;
        for (int a = 0; a < 2**AW; a++) begin
            mem[a]    = pat(a);
            shadow[a] = pat(a);
        end
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_bram_we", bram_we, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_bram_wdata", bram_wdata, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_rd_ready", rd_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single write then single-word burst of the same address
        wr(11'd5, 36'h123456789);
        rd(11'd5, 8'd0, acc);
        repeat (4) tick();

        // Burst wrapping past the top of the address space
        rd(11'h7FE, 8'd3, acc);
        repeat (6) tick();

        // Write and burst requested together: write first
        cfg_valid = 1'b1; cfg_addr = 11'h050; cfg_data = 36'hABCDE0123;
        rd_valid  = 1'b1; rd_base  = 11'h050; rd_len   = 8'd1;
        @(negedge clk);
        chk("both_cfg_ready", cfg_ready, 1);
        chk("both_rd_ready", rd_ready, 0);
        wr_q.push_back('{11'h050, 36'hABCDE0123, cyc + 1});
        shadow[11'h050] = 36'hABCDE0123;
        first = cyc;
        tick();
        cfg_valid = 1'b0;
        rd(11'h050, 8'd1, acc);
        chk("both_rd_acc_cyc", acc, first + 2);
        repeat (4) tick();

        // Write held during an 8-word burst
        rd(11'h100, 8'd7, acc);
        cfg_valid = 1'b1; cfg_addr = 11'h103; cfg_data = 36'h0FEDCBA98;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("busy_cfg_ready", cfg_ready, 0);
            tick();
        end
        @(negedge clk);
        chk("post_burst_cfg_ready", cfg_ready, 1);
        wr_q.push_back('{11'h103, 36'h0FEDCBA98, cyc + 1});
        shadow[11'h103] = 36'h0FEDCBA98;
        tick();
        cfg_valid = 1'b0;
        rd(11'h103, 8'd0, acc);
        repeat (3) tick();

        // Back-to-back single-word bursts
        rd(11'h020, 8'd0, acc);
        rd(11'h021, 8'd0, acc2);
        chk("b2b_acc_gap", acc2 - acc, 3);
        repeat (3) tick();
        chk("b2b_out_gap", last_out_cyc - prev_out_cyc, 3);

        // Reset on the third issue cycle of an 8-word burst
        rd(11'h040, 8'd7, acc);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rd_q.delete();
        word_q.delete();
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_bram_en", bram_en, 0);
        chk("abort_rd_ready", rd_ready, 1);
        chk("abort_cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;
        repeat (12) tick();

        // BRAM contents survive reset
        rd(11'd5, 8'd0, acc);
        repeat (3) tick();

        // A few random write/burst pairs
        for (int n = 0; n < 4; n++) begin
            wr(AW'($urandom_range(0, 2**AW - 1)), {4'($urandom), 32'($urandom)});
            rd(AW'($urandom_range(0, 2**AW - 1)), LW'($urandom_range(0, 5)), acc);
        end
        repeat (12) tick();

        chk("rd_q_empty", rd_q.size(), 0);
        chk("word_q_empty", word_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
